// File: rtl/icache_req_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : icache_req_arbiter                                              |
// | Purpose  : Shares one i-cache request/response channel between the demand  |
// |            fetch port and a next-line prefetch port. Requests are issued   |
// |            in grant order; an owner FIFO steers the in-order responses     |
// |            back to the port that issued them. A front-end flush discards   |
// |            every outstanding response.                                     |
// | Options  : ICACHE_ARB_PREFETCH_EN - when defined the prefetch port is live |
// |            (starvation counter, LOCK_P state, owner bit in the FIFO).      |
// |            When undefined the prefetch port is inert and the block is a    |
// |            plain pass-through for fetch.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module icache_req_arbiter #(
  parameter int XLEN       = 64,
  parameter int DATA_W     = 128,
  parameter int MAX_OUT    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  // fetch port
  input  logic [XLEN-1:0]   f_addr_i,
  input  logic              f_addr_valid_i,
  output logic              f_addr_ready_o,
  output logic [DATA_W-1:0] f_data_o,
  output logic              f_data_valid_o,
  input  logic              f_data_ready_i,
  // prefetch port
  input  logic [XLEN-1:0]   p_addr_i,
  input  logic              p_addr_valid_i,
  output logic              p_addr_ready_o,
  output logic [DATA_W-1:0] p_data_o,
  output logic              p_data_valid_o,
  input  logic              p_data_ready_i,
  // i-cache channel
  output logic [XLEN-1:0]   addr_o,
  output logic              addr_valid_o,
  input  logic              addr_ready_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o
);

  localparam int c_PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int c_CNT_W = $clog2(MAX_OUT + 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LOCK_F = 2'd1;
`ifdef ICACHE_ARB_PREFETCH_EN
  localparam logic [1:0] c_LOCK_P = 2'd2;
  localparam int         c_STV_W  = $clog2(STARVE_MAX + 1);
`endif

  // Grant lock state and the address held while a request is stalled
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [XLEN-1:0]    r_lock_addr;

  // Owner FIFO bookkeeping
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [MAX_OUT-1:0] r_drop;
`ifdef ICACHE_ARB_PREFETCH_EN
  logic [MAX_OUT-1:0] r_owner;      // 1 = prefetch issued this entry
  logic [c_STV_W-1:0] r_starve;
`endif

  logic               w_full;
  logic               w_empty;
  logic               w_sel_f;
  logic               w_sel_p;
  logic               w_addr_valid;
  logic [XLEN-1:0]    w_req_addr;
  logic               w_push;
  logic               w_pop;
  logic               w_head_drop;
  logic               w_head_owner;
  logic               w_fwd;

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(MAX_OUT - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign w_full  = (r_count == c_CNT_W'(MAX_OUT));
  assign w_empty = (r_count == '0);

  // Lock state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: lock when an offered request is stalled, release on accept or flush
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_addr_valid && !addr_ready_i) begin
`ifdef ICACHE_ARB_PREFETCH_EN
          w_state_nxt = w_sel_p ? c_LOCK_P : c_LOCK_F;
`else
          w_state_nxt = c_LOCK_F;
`endif
        end
      end
      c_LOCK_F: begin
        if (addr_ready_i || flush_i) w_state_nxt = c_IDLE;
      end
`ifdef ICACHE_ARB_PREFETCH_EN
      c_LOCK_P: begin
        if (addr_ready_i || flush_i) w_state_nxt = c_IDLE;
      end
`endif
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Grant selection and request outputs; a held grant ignores arbitration
  always_comb begin
    w_sel_f = 1'b0;
    w_sel_p = 1'b0;
    case (r_state)
      c_LOCK_F: w_sel_f = 1'b1;
`ifdef ICACHE_ARB_PREFETCH_EN
      c_LOCK_P: w_sel_p = 1'b1;
`endif
      default: begin
`ifdef ICACHE_ARB_PREFETCH_EN
        // Prefetch wins only when fetch is idle or prefetch has starved
        if (p_addr_valid_i && (!f_addr_valid_i || r_starve == c_STV_W'(STARVE_MAX))) begin
          w_sel_p = 1'b1;
        end else begin
          w_sel_f = f_addr_valid_i;
        end
`else
        w_sel_f = f_addr_valid_i;
`endif
      end
    endcase
    w_addr_valid = (w_sel_f | w_sel_p) & ~w_full & ~flush_i & rst_n_i;
    if (r_state != c_IDLE) begin
      w_req_addr = r_lock_addr;
    end else if (w_sel_p) begin
      w_req_addr = p_addr_i;
    end else begin
      w_req_addr = f_addr_i;
    end
  end

  assign addr_o         = w_req_addr;
  assign addr_valid_o   = w_addr_valid;
  assign f_addr_ready_o = w_sel_f & w_addr_valid & addr_ready_i;
  assign w_push         = w_addr_valid & addr_ready_i;

`ifdef ICACHE_ARB_PREFETCH_EN
  assign p_addr_ready_o = w_sel_p & w_addr_valid & addr_ready_i;
  assign w_head_owner   = r_owner[r_rd_ptr];
`else
  logic w_unused_pf;
  assign p_addr_ready_o = 1'b0;
  assign w_head_owner   = 1'b0;
  assign w_unused_pf    = ^{p_addr_i, p_addr_valid_i, p_data_ready_i};
`endif

  // Response steering: the FIFO head names the destination, dropped entries are swallowed
  assign w_head_drop    = r_drop[r_rd_ptr];
  assign w_fwd          = data_valid_i & ~w_empty & ~w_head_drop & ~flush_i;
  assign f_data_o       = data_i;
  assign p_data_o       = data_i;
  assign f_data_valid_o = w_fwd & ~w_head_owner;
`ifdef ICACHE_ARB_PREFETCH_EN
  assign p_data_valid_o = w_fwd & w_head_owner;
  assign data_ready_o   = w_empty | w_head_drop | flush_i |
                          (w_head_owner ? p_data_ready_i : f_data_ready_i);
`else
  assign p_data_valid_o = 1'b0;
  assign data_ready_o   = w_empty | w_head_drop | flush_i | f_data_ready_i;
`endif
  assign w_pop          = data_valid_i & data_ready_o & ~w_empty;

  // Capture the address of a stalled request so it stays put until accepted
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lock_addr <= '0;
    end else if (r_state == c_IDLE && w_addr_valid && !addr_ready_i) begin
      r_lock_addr <= w_req_addr;
    end
  end

  // Owner FIFO: push on cache accept, pop on response handshake, flush marks all dropped
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_drop   <= '0;
`ifdef ICACHE_ARB_PREFETCH_EN
      r_owner  <= '0;
`endif
    end else begin
      if (w_push) begin
        r_drop[r_wr_ptr]  <= 1'b0;
`ifdef ICACHE_ARB_PREFETCH_EN
        r_owner[r_wr_ptr] <= w_sel_p;
`endif
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      // No push can coincide with a flush, so marking every slot is safe
      if (flush_i) begin
        r_drop <= '1;
      end
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

`ifdef ICACHE_ARB_PREFETCH_EN
  // Starvation counter: counts cycles prefetch waits without being offered to the cache
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_starve <= '0;
    end else if (flush_i || p_addr_ready_o) begin
      r_starve <= '0;
    end else if (p_addr_valid_i && !(w_sel_p && w_addr_valid) &&
                 r_starve != c_STV_W'(STARVE_MAX)) begin
      r_starve <= r_starve + c_STV_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_req_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_icache_req_arbiter                                           |
// | Purpose  : Randomized bench for icache_req_arbiter with a queue-based      |
// |            reference model and a response-data scoreboard per port.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_icache_req_arbiter;

  localparam int XLEN       = 64;
  localparam int DATA_W     = 128;
  localparam int MAX_OUT    = 4;
  localparam int STARVE_MAX = 8;
`ifdef ICACHE_ARB_PREFETCH_EN
  localparam bit c_PF_EN = 1'b1;
`else
  localparam bit c_PF_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              flush_i;
  logic [XLEN-1:0]   f_addr_i;
  logic              f_addr_valid_i;
  logic              f_addr_ready_o;
  logic [DATA_W-1:0] f_data_o;
  logic              f_data_valid_o;
  logic              f_data_ready_i;
  logic [XLEN-1:0]   p_addr_i;
  logic              p_addr_valid_i;
  logic              p_addr_ready_o;
  logic [DATA_W-1:0] p_data_o;
  logic              p_data_valid_o;
  logic              p_data_ready_i;
  logic [XLEN-1:0]   addr_o;
  logic              addr_valid_o;
  logic              addr_ready_i;
  logic [DATA_W-1:0] data_i;
  logic              data_valid_i;
  logic              data_ready_o;

  icache_req_arbiter #(
    .XLEN(XLEN), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .f_addr_i(f_addr_i), .f_addr_valid_i(f_addr_valid_i), .f_addr_ready_o(f_addr_ready_o),
    .f_data_o(f_data_o), .f_data_valid_o(f_data_valid_o), .f_data_ready_i(f_data_ready_i),
    .p_addr_i(p_addr_i), .p_addr_valid_i(p_addr_valid_i), .p_addr_ready_o(p_addr_ready_o),
    .p_data_o(p_data_o), .p_data_valid_o(p_data_valid_o), .p_data_ready_i(p_data_ready_i),
    .addr_o(addr_o), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic owner;   // 1 = prefetch
    logic drop;
  } ent_t;

  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  ent_t              m_q[$];
  int                m_starve;
  int                m_lock;          // 0 none, 1 fetch, 2 prefetch
  logic [XLEN-1:0]   m_lock_addr;
  logic [DATA_W-1:0] f_exp[$];
  logic [DATA_W-1:0] p_exp[$];
  logic [DATA_W-1:0] cache_q[$];      // responses the cache still owes
  bit                f_acc, p_acc;
  int                pf_acc_cnt;

  // Monitor scratch
  int                chosen;
  bit                e_av, e_fr, e_pr, e_fdv, e_pdv, e_dr, e_full, e_empty;
  logic [XLEN-1:0]   e_addr;
  ent_t              hd, tmp;

  function automatic logic [DATA_W-1:0] f_resp(input logic [XLEN-1:0] a);
    return {a ^ 64'hA5A5_5A5A_0F0F_F0F0, a};
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event occurred with nothing expected at %0t", name, $time);
  endtask

  // Monitor: predict every output from the model, score response data, advance the model
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      check("rst_addr_valid", addr_valid_o, 0);
      check("rst_f_addr_ready", f_addr_ready_o, 0);
      check("rst_p_addr_ready", p_addr_ready_o, 0);
      check("rst_f_data_valid", f_data_valid_o, 0);
      check("rst_p_data_valid", p_data_valid_o, 0);
      check("rst_data_ready", data_ready_o, 1);
      m_q.delete(); f_exp.delete(); p_exp.delete();
      m_starve = 0; m_lock = 0; f_acc = 0; p_acc = 0;
      if (data_valid_i && data_ready_o && cache_q.size() > 0) void'(cache_q.pop_front());
    end else begin
      e_full = (m_q.size() == MAX_OUT);
      if (m_lock != 0) chosen = m_lock;
      else if (f_addr_valid_i)
        chosen = (c_PF_EN && p_addr_valid_i && m_starve == STARVE_MAX) ? 2 : 1;
      else if (c_PF_EN && p_addr_valid_i) chosen = 2;
      else chosen = 0;
      e_av   = (chosen != 0) && !e_full && !flush_i;
      e_addr = (m_lock != 0) ? m_lock_addr : ((chosen == 2) ? p_addr_i : f_addr_i);
      e_fr   = e_av && chosen == 1 && addr_ready_i;
      e_pr   = e_av && chosen == 2 && addr_ready_i;
      check("addr_valid", addr_valid_o, e_av);
      if (e_av) check("addr", addr_o, e_addr);
      check("f_addr_ready", f_addr_ready_o, e_fr);
      check("p_addr_ready", p_addr_ready_o, e_pr);

      e_empty = (m_q.size() == 0);
      hd      = e_empty ? ent_t'(2'b00) : m_q[0];
      e_fdv   = data_valid_i && !e_empty && !hd.drop && !flush_i && !hd.owner;
      e_pdv   = data_valid_i && !e_empty && !hd.drop && !flush_i && hd.owner;
      e_dr    = e_empty || hd.drop || flush_i || (hd.owner ? p_data_ready_i : f_data_ready_i);
      check("f_data_valid", f_data_valid_o, e_fdv);
      check("p_data_valid", p_data_valid_o, e_pdv);
      check("data_ready", data_ready_o, e_dr);

      // Scoreboard: each delivered response must be the oldest one owed to that port
      if (f_data_valid_o && f_data_ready_i) begin
        if (f_exp.size() == 0) fail_now("f_data_extra");
        else check("f_data", f_data_o, f_exp.pop_front());
      end
      if (p_data_valid_o && p_data_ready_i) begin
        if (p_exp.size() == 0) fail_now("p_data_extra");
        else check("p_data", p_data_o, p_exp.pop_front());
      end

      if (data_valid_i && !e_empty && e_dr) void'(m_q.pop_front());
      if (flush_i) begin
        foreach (m_q[i]) begin tmp = m_q[i]; tmp.drop = 1'b1; m_q[i] = tmp; end
        f_exp.delete(); p_exp.delete();
      end
      if (e_av && addr_ready_i) begin
        m_q.push_back(ent_t'({chosen == 2, 1'b0}));
        if (chosen == 2) begin p_exp.push_back(f_resp(e_addr)); pf_acc_cnt++; end
        else f_exp.push_back(f_resp(e_addr));
      end
      f_acc = e_fr;
      p_acc = e_pr;
      if (flush_i || e_pr) m_starve = 0;
      else if (p_addr_valid_i && !(chosen == 2 && e_av) && m_starve < STARVE_MAX) m_starve++;
      if (flush_i) m_lock = 0;
      else if (m_lock != 0) begin
        if (addr_ready_i) m_lock = 0;
      end else if (e_av && !addr_ready_i) begin
        m_lock = chosen; m_lock_addr = e_addr;
      end

      if (addr_valid_o && addr_ready_i) cache_q.push_back(f_resp(addr_o));
      if (data_valid_i && data_ready_o && cache_q.size() > 0) void'(cache_q.pop_front());
    end
  end

  // Requesters hold valid and address until accepted
  bit f_pend, p_pend;

  function automatic bit pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic drive_cycle(input int f_pct, input int p_pct, input int rdy_pct,
                             input int resp_pct, input int dr_pct, input int fl_pct);
    @(posedge clk_i); #1;
    if (f_acc) f_pend = 0;
    if (p_acc) p_pend = 0;
    if (!f_pend && pct(f_pct)) begin
      f_pend = 1; f_addr_i = {32'h0, $urandom} & ~64'hF;
    end
    if (!p_pend && pct(p_pct)) begin
      p_pend = 1; p_addr_i = {32'h1, $urandom} & ~64'hF;
    end
    f_addr_valid_i = f_pend;
    p_addr_valid_i = p_pend;
    addr_ready_i   = pct(rdy_pct);
    flush_i        = pct(fl_pct);
    data_valid_i   = (cache_q.size() > 0) && pct(resp_pct);
    data_i         = data_valid_i ? cache_q[0] : {$urandom, $urandom, $urandom, $urandom};
    f_data_ready_i = pct(dr_pct);
    p_data_ready_i = pct(dr_pct);
  endtask

  task automatic run_phase(input int n, input int f_pct, input int p_pct, input int rdy_pct,
                           input int resp_pct, input int dr_pct, input int fl_pct);
    for (int i = 0; i < n; i++) drive_cycle(f_pct, p_pct, rdy_pct, resp_pct, dr_pct, fl_pct);
  endtask

  // Reset with requests pending, then let the cache retire its stale responses
  task automatic do_reset(input int cycles);
    @(posedge clk_i); #1;
    rst_n_i = 0; f_pend = 0; p_pend = 0;
    f_addr_valid_i = 1; p_addr_valid_i = 1; addr_ready_i = 1; flush_i = 0;
    f_data_ready_i = 1; p_data_ready_i = 1;
    data_valid_i = (cache_q.size() > 0);
    data_i = data_valid_i ? cache_q[0] : '0;
    repeat (cycles) begin
      @(posedge clk_i); #1;
      data_valid_i = (cache_q.size() > 0);
      data_i = data_valid_i ? cache_q[0] : '0;
    end
    rst_n_i = 1;
    f_addr_valid_i = 0; p_addr_valid_i = 0;
    for (int i = 0; i < 50 && cache_q.size() > 0; i++) drive_cycle(0, 0, 100, 100, 100, 0);
    if (cache_q.size() > 0) fail_now("stale_drain_timeout");
  endtask

  initial begin
    rst_n_i = 0; flush_i = 0; f_addr_i = '0; f_addr_valid_i = 0; f_data_ready_i = 0;
    p_addr_i = '0; p_addr_valid_i = 0; p_data_ready_i = 0; addr_ready_i = 0;
    data_i = '0; data_valid_i = 0; f_pend = 0; p_pend = 0; pf_acc_cnt = 0;
    do_reset(3);
    run_phase(200,  70,   0,  80,  60,  90, 0);   // fetch only
    pf_acc_cnt = 0;
    run_phase(300, 100, 100, 100,  70,  90, 0);   // constant contention
    check("pf_grants_under_contention", pf_acc_cnt > 0, c_PF_EN);
    run_phase(150, 100,  50, 100,  10, 100, 0);   // FIFO mostly full
    run_phase(300,  60,  60,  30,  60,  80, 5);   // stalls and flushes
    run_phase(30,  100, 100,  50,   0, 100, 0);   // build outstanding work
    do_reset(2);                                  // reset with responses outstanding
    run_phase(500,  50,  50,  60,  50,  70, 3);   // mixed traffic
    for (int i = 0; i < 200 && (f_pend || cache_q.size() > 0); i++)
      drive_cycle(0, 0, 100, 100, 100, 0);
    repeat (2) drive_cycle(0, 0, 100, 100, 100, 0);
    check("f_exp_drained", f_exp.size(), 0);
    check("p_exp_drained", c_PF_EN ? p_exp.size() : 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
